// File: rtl/ob_level_match_engine_pkg.sv
// Shared types for the level-aggregated order book engine: command opcodes,
// FSM states, side encoding and the trade record.
package ob_pkg;

   // trade_t is sized for the default book geometry (256 ticks, 16-bit qty).
   localparam int OB_PRICE_WIDTH = 8;
   localparam int OB_QTY_WIDTH   = 16;

   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_CANCEL = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MATCH = 2'd1,
      S_CLEAR = 2'd2
   } state_e;

   localparam logic BID = 1'b0;
   localparam logic ASK = 1'b1;

   typedef struct packed {
      logic [OB_PRICE_WIDTH-1:0] bid_px;
      logic [OB_PRICE_WIDTH-1:0] ask_px;
      logic [OB_QTY_WIDTH-1:0]   qty;
   } trade_t;

   function automatic logic [OB_QTY_WIDTH-1:0] qty_min(
      input logic [OB_QTY_WIDTH-1:0] a,
      input logic [OB_QTY_WIDTH-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ob_level_match_engine_best_scan.sv
// Two-level priority scan over an active-level bitmap: pick a group, then a
// bit inside it. HIGH_FIRST selects the highest index (bids) or lowest (asks).
module ob_best_scan #(
   parameter int PRICE_LEVELS = 256,
   parameter int GROUP        = 16,
   parameter bit HIGH_FIRST   = 1'b1,
   localparam int PW = $clog2(PRICE_LEVELS),
   localparam int NG = PRICE_LEVELS / GROUP,
   localparam int GW = (NG > 1) ? $clog2(NG) : 1,
   localparam int BW = (GROUP > 1) ? $clog2(GROUP) : 1
) (
   input  logic [PRICE_LEVELS-1:0] i_active,
   output logic [PW-1:0]           o_idx,
   output logic                    o_empty
);

   logic [GROUP-1:0] w_groups [NG];
   logic [NG-1:0]    w_group_valid;
   logic [GROUP-1:0] w_grp_bits;
   logic [GW-1:0]    w_grp;
   logic [BW-1:0]    w_bit;

   always_comb begin
      for (int g = 0; g < NG; g++) begin
         w_groups[g]      = i_active[g*GROUP +: GROUP];
         w_group_valid[g] = |i_active[g*GROUP +: GROUP];
      end
   end

   // Last match in loop order wins, so the loop direction sets the priority.
   always_comb begin
      w_grp = '0;
      w_bit = '0;
      if (HIGH_FIRST) begin
         for (int g = 0; g < NG; g++)
            if (w_group_valid[g]) w_grp = GW'(g);
      end else begin
         for (int g = NG - 1; g >= 0; g--)
            if (w_group_valid[g]) w_grp = GW'(g);
      end
      w_grp_bits = w_groups[w_grp];
      if (HIGH_FIRST) begin
         for (int b = 0; b < GROUP; b++)
            if (w_grp_bits[b]) w_bit = BW'(b);
      end else begin
         for (int b = GROUP - 1; b >= 0; b--)
            if (w_grp_bits[b]) w_bit = BW'(b);
      end
   end

   assign o_idx   = PW'(w_grp) * PW'(GROUP) + PW'(w_bit);
   assign o_empty = ~|w_group_valid;

endmodule

// File: rtl/ob_level_match_engine.sv
// Level-aggregated order book: one resting quantity per (side, price), best
// bid/ask scan, and a crossing engine that emits one trade per handshake.
//
// state   | meaning
// S_IDLE  | accept add/cancel/clear commands while the book is not crossed
// S_MATCH | book crossed; offer best-bid/best-ask trades until uncrossed
// S_CLEAR | walk every level of the latched side, zeroing one per cycle
import ob_pkg::*;

module ob_level_match_engine #(
   parameter int PRICE_LEVELS = 256,
   parameter int GROUP        = 16,
   parameter int QTY_WIDTH    = 16,
   parameter int PRICE_WIDTH  = $clog2(PRICE_LEVELS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [1:0]             i_cmd_op,
   input  logic                   i_cmd_side,
   input  logic [PRICE_WIDTH-1:0] i_cmd_price,
   input  logic [QTY_WIDTH-1:0]   i_cmd_qty,
   output logic                   o_trade_valid,
   input  logic                   i_trade_ready,
   output logic [PRICE_WIDTH-1:0] o_trade_bid_px,
   output logic [PRICE_WIDTH-1:0] o_trade_ask_px,
   output logic [QTY_WIDTH-1:0]   o_trade_qty,
   output logic [PRICE_WIDTH-1:0] o_best_bid,
   output logic [PRICE_WIDTH-1:0] o_best_ask,
   output logic                   o_bid_empty,
   output logic                   o_ask_empty,
   output logic                   o_busy,
   output logic                   o_err_sat,
   output logic                   o_err_under,
   output logic                   o_err_op,
   input  logic                   i_err_clr
);

   localparam logic [QTY_WIDTH-1:0] QTY_MAX = '1;

   state_e r_state, w_state_nxt;

   logic [QTY_WIDTH-1:0]    r_bid_qty [PRICE_LEVELS];
   logic [QTY_WIDTH-1:0]    r_ask_qty [PRICE_LEVELS];
   logic                    r_clr_side;
   logic [PRICE_WIDTH-1:0]  r_clr_cnt;
   logic                    r_err_sat, r_err_under, r_err_op;

   logic [PRICE_LEVELS-1:0] w_bid_act, w_ask_act;
   logic [PRICE_WIDTH-1:0]  w_best_bid, w_best_ask;
   logic                    w_bid_empty, w_ask_empty, w_crossed;

   op_e                     w_op;
   logic [QTY_WIDTH-1:0]    w_lvl_cur, w_lvl_new;
   logic [QTY_WIDTH:0]      w_sum;
   logic                    w_set_sat, w_set_under, w_set_op;
   logic                    w_do_upd, w_do_trade, w_do_clr_start, w_do_clr_step;
   logic [QTY_WIDTH-1:0]    w_bid_top, w_ask_top;
   trade_t                  w_trade;

   always_comb begin
      for (int i = 0; i < PRICE_LEVELS; i++) begin
         w_bid_act[i] = (r_bid_qty[i] != '0);
         w_ask_act[i] = (r_ask_qty[i] != '0);
      end
   end

   ob_best_scan #(.PRICE_LEVELS(PRICE_LEVELS), .GROUP(GROUP), .HIGH_FIRST(1'b1)) u_bid_scan (
      .i_active (w_bid_act),
      .o_idx    (w_best_bid),
      .o_empty  (w_bid_empty)
   );

   ob_best_scan #(.PRICE_LEVELS(PRICE_LEVELS), .GROUP(GROUP), .HIGH_FIRST(1'b0)) u_ask_scan (
      .i_active (w_ask_act),
      .o_idx    (w_best_ask),
      .o_empty  (w_ask_empty)
   );

   assign w_crossed = !w_bid_empty && !w_ask_empty && (w_best_bid >= w_best_ask);

   // Add saturates at all-ones; cancel clamps at zero.
   assign w_op      = op_e'(i_cmd_op);
   assign w_lvl_cur = (i_cmd_side == ASK) ? r_ask_qty[i_cmd_price] : r_bid_qty[i_cmd_price];
   assign w_sum     = {1'b0, w_lvl_cur} + {1'b0, i_cmd_qty};

   always_comb begin
      w_lvl_new   = w_lvl_cur;
      w_set_sat   = 1'b0;
      w_set_under = 1'b0;
      case (w_op)
         OP_ADD: begin
            if (w_sum[QTY_WIDTH]) begin
               w_lvl_new = QTY_MAX;
               w_set_sat = 1'b1;
            end else begin
               w_lvl_new = w_sum[QTY_WIDTH-1:0];
            end
         end
         OP_CANCEL: begin
            if (i_cmd_qty > w_lvl_cur) begin
               w_lvl_new   = '0;
               w_set_under = 1'b1;
            end else begin
               w_lvl_new = w_lvl_cur - i_cmd_qty;
            end
         end
         default: ;
      endcase
   end

   assign w_bid_top     = r_bid_qty[w_best_bid];
   assign w_ask_top     = r_ask_qty[w_best_ask];
   assign w_trade.bid_px = OB_PRICE_WIDTH'(w_best_bid);
   assign w_trade.ask_px = OB_PRICE_WIDTH'(w_best_ask);
   assign w_trade.qty    = qty_min(OB_QTY_WIDTH'(w_bid_top), OB_QTY_WIDTH'(w_ask_top));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      o_cmd_ready    = 1'b0;
      o_trade_valid  = 1'b0;
      w_do_upd       = 1'b0;
      w_do_trade     = 1'b0;
      w_do_clr_start = 1'b0;
      w_do_clr_step  = 1'b0;
      w_set_op       = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_cmd_ready = !w_crossed;
            if (w_crossed) begin
               w_state_nxt = S_MATCH;
            end else if (i_cmd_valid) begin
               case (w_op)
                  OP_CLEAR: begin
                     w_state_nxt    = S_CLEAR;
                     w_do_clr_start = 1'b1;
                  end
                  OP_RSVD: w_set_op = 1'b1;
                  default: w_do_upd = (i_cmd_qty != '0);
               endcase
            end
         end
         S_MATCH: begin
            o_trade_valid = w_crossed;
            w_do_trade    = w_crossed && i_trade_ready;
            if (!w_crossed) w_state_nxt = S_IDLE;
         end
         S_CLEAR: begin
            w_do_clr_step = 1'b1;
            if (r_clr_cnt == PRICE_WIDTH'(PRICE_LEVELS - 1)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PRICE_LEVELS; i++) begin
            r_bid_qty[i] <= '0;
            r_ask_qty[i] <= '0;
         end
         r_clr_side <= BID;
         r_clr_cnt  <= '0;
      end else begin
         if (w_do_upd) begin
            if (i_cmd_side == ASK) r_ask_qty[i_cmd_price] <= w_lvl_new;
            else                   r_bid_qty[i_cmd_price] <= w_lvl_new;
         end
         if (w_do_trade) begin
            r_bid_qty[w_best_bid] <= w_bid_top - QTY_WIDTH'(w_trade.qty);
            r_ask_qty[w_best_ask] <= w_ask_top - QTY_WIDTH'(w_trade.qty);
         end
         if (w_do_clr_start) begin
            r_clr_side <= i_cmd_side;
            r_clr_cnt  <= '0;
         end
         if (w_do_clr_step) begin
            if (r_clr_side == ASK) r_ask_qty[r_clr_cnt] <= '0;
            else                   r_bid_qty[r_clr_cnt] <= '0;
            r_clr_cnt <= r_clr_cnt + PRICE_WIDTH'(1);
         end
      end
   end

   // A clear in the same cycle as a failing command wins; that error is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_sat   <= 1'b0;
         r_err_under <= 1'b0;
         r_err_op    <= 1'b0;
      end else if (i_err_clr) begin
         r_err_sat   <= 1'b0;
         r_err_under <= 1'b0;
         r_err_op    <= 1'b0;
      end else begin
         if (w_do_upd && w_set_sat)   r_err_sat   <= 1'b1;
         if (w_do_upd && w_set_under) r_err_under <= 1'b1;
         if (w_set_op)                r_err_op    <= 1'b1;
      end
   end

   assign o_trade_bid_px = PRICE_WIDTH'(w_trade.bid_px);
   assign o_trade_ask_px = PRICE_WIDTH'(w_trade.ask_px);
   assign o_trade_qty    = QTY_WIDTH'(w_trade.qty);
   assign o_best_bid     = w_best_bid;
   assign o_best_ask     = w_best_ask;
   assign o_bid_empty    = w_bid_empty;
   assign o_ask_empty    = w_ask_empty;
   assign o_busy         = (r_state != S_IDLE);
   assign o_err_sat      = r_err_sat;
   assign o_err_under    = r_err_under;
   assign o_err_op       = r_err_op;

endmodule

// File: tb/tb_ob_level_match_engine.sv
// Bench for ob_level_match_engine: directed scenarios plus a randomized
// command stream checked against an array-based book model.
module tb_ob_level_match_engine;

   localparam int PL = 256;

   logic        clk, reset;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic        cmd_side;
   logic [7:0]  cmd_price;
   logic [15:0] cmd_qty;
   logic        trade_valid, trade_ready;
   logic [7:0]  trade_bid_px, trade_ask_px;
   logic [15:0] trade_qty;
   logic [7:0]  best_bid, best_ask;
   logic        bid_empty, ask_empty, busy;
   logic        err_sat, err_under, err_op, err_clr;

   ob_level_match_engine dut (
      .clk(clk), .reset(reset),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
      .i_cmd_side(cmd_side), .i_cmd_price(cmd_price), .i_cmd_qty(cmd_qty),
      .o_trade_valid(trade_valid), .i_trade_ready(trade_ready),
      .o_trade_bid_px(trade_bid_px), .o_trade_ask_px(trade_ask_px), .o_trade_qty(trade_qty),
      .o_best_bid(best_bid), .o_best_ask(best_ask),
      .o_bid_empty(bid_empty), .o_ask_empty(ask_empty), .o_busy(busy),
      .o_err_sat(err_sat), .o_err_under(err_under), .o_err_op(err_op),
      .i_err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int b; int a; int q; } tr_t;

   int  m_bid [PL];
   int  m_ask [PL];
   bit  m_sat, m_under, m_op;
   tr_t exp_q [$];
   int  n_tests = 0, n_fail = 0;
   int  n_trades, last_b, last_a, last_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_best_bid();
      for (int i = PL - 1; i >= 0; i--) if (m_bid[i] != 0) return i;
      return -1;
   endfunction

   function automatic int m_best_ask();
      for (int i = 0; i < PL; i++) if (m_ask[i] != 0) return i;
      return -1;
   endfunction

   function automatic void model_match();
      int b, a, q;
      forever begin
         b = m_best_bid();
         a = m_best_ask();
         if (b < 0 || a < 0 || b < a) break;
         q = (m_bid[b] < m_ask[a]) ? m_bid[b] : m_ask[a];
         exp_q.push_back('{b: b, a: a, q: q});
         m_bid[b] -= q;
         m_ask[a] -= q;
      end
   endfunction

   function automatic void model_cmd(input int op, input int side, input int px, input int qty);
      int lvl;
      lvl = side ? m_ask[px] : m_bid[px];
      case (op)
         0: if (qty != 0) begin
               lvl += qty;
               if (lvl > 65535) begin lvl = 65535; m_sat = 1; end
            end
         1: if (qty != 0) begin
               if (qty > lvl) begin lvl = 0; m_under = 1; end
               else lvl -= qty;
            end
         3: m_op = 1;
         default: ;
      endcase
      if (op == 2) begin
         for (int i = 0; i < PL; i++) if (side) m_ask[i] = 0; else m_bid[i] = 0;
      end else if (side) m_ask[px] = lvl;
      else m_bid[px] = lvl;
      model_match();
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < PL; i++) begin m_bid[i] = 0; m_ask[i] = 0; end
      m_sat = 0; m_under = 0; m_op = 0;
      exp_q.delete();
   endfunction

   task automatic apply_reset();
      reset = 1'b1; cmd_valid = 1'b0; err_clr = 1'b0; trade_ready = 1'b1;
      cmd_op = '0; cmd_side = 1'b0; cmd_price = '0; cmd_qty = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic do_cmd(input int op, input int side, input int px, input int qty);
      int n = 0;
      cmd_op = 2'(op); cmd_side = 1'(side); cmd_price = 8'(px); cmd_qty = 16'(qty);
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) check("cmd_accept_timeout", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      model_cmd(op, side, px, qty);
   endtask

   task automatic settle(input int stall, input bit rnd);
      int n = 0;
      int left = stall;
      n_trades = 0;
      while (!cmd_ready && n < 3000) begin
         if (rnd) trade_ready = 1'($urandom_range(0, 1));
         else     trade_ready = (trade_valid && left > 0) ? 1'b0 : 1'b1;
         if (trade_valid) begin
            check("busy_in_match", busy, 1);
            if (exp_q.size() == 0) check("unexpected_trade", trade_valid, 0);
            else begin
               check("trade_bid_px", trade_bid_px, exp_q[0].b);
               check("trade_ask_px", trade_ask_px, exp_q[0].a);
               check("trade_qty",    trade_qty,    exp_q[0].q);
               if (trade_ready) begin
                  last_b = exp_q[0].b; last_a = exp_q[0].a; last_q = exp_q[0].q;
                  void'(exp_q.pop_front());
                  n_trades++;
               end else if (!rnd) left--;
            end
         end
         @(negedge clk);
         n++;
      end
      trade_ready = 1'b1;
      check("settle_ready", cmd_ready, 1);
      check("trades_pending", exp_q.size(), 0);
   endtask

   task automatic check_book(input string tag);
      int b, a;
      b = m_best_bid();
      a = m_best_ask();
      check({tag, "_best_bid"},  best_bid,  (b < 0) ? 0 : b);
      check({tag, "_best_ask"},  best_ask,  (a < 0) ? 0 : a);
      check({tag, "_bid_empty"}, bid_empty, (b < 0));
      check({tag, "_ask_empty"}, ask_empty, (a < 0));
      check({tag, "_trade_valid"}, trade_valid, 0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_err_sat"},   err_sat,   m_sat);
      check({tag, "_err_under"}, err_under, m_under);
      check({tag, "_err_op"},    err_op,    m_op);
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_sat = 0; m_under = 0; m_op = 0;
   endtask

   initial begin
      int n, r, op, side, px, qty;

      apply_reset();
      check("rst_cmd_ready", cmd_ready, 1);
      check_book("rst");

      // Resting bid and ask, not crossed
      do_cmd(0, 0, 10, 5);  settle(0, 0);
      do_cmd(0, 1, 20, 7);  settle(0, 0);
      check("t1_best_bid", best_bid, 10);
      check("t1_best_ask", best_ask, 20);
      check_book("t1");

      // Crossing ask executes one trade
      do_cmd(0, 1, 8, 3);   settle(0, 0);
      check("t2_ntrades", n_trades, 1);
      check("t2_trade", {8'(last_b), 8'(last_a), 16'(last_q)}, {8'd10, 8'd8, 16'd3});
      check("t2_best_ask", best_ask, 20);
      check_book("t2");

      // Two-level sweep with downstream back-pressure
      do_cmd(0, 0, 12, 4);  settle(0, 0);
      do_cmd(0, 0, 11, 4);  settle(0, 0);
      do_cmd(0, 1, 11, 6);  settle(3, 0);
      check("t3_ntrades", n_trades, 2);
      check("t3_last", {8'(last_b), 8'(last_a), 16'(last_q)}, {8'd11, 8'd11, 16'd2});
      check_book("t3");
      do_cmd(1, 0, 11, 2);  settle(0, 0);
      check("t3_bid11_gone", best_bid, 10);
      check_book("t3b");

      // Zero-quantity commands and error flags
      apply_reset();
      do_cmd(0, 0, 5, 0);   settle(0, 0);
      do_cmd(1, 0, 5, 0);   settle(0, 0);
      check("zero_qty_empty", bid_empty, 1);
      check_book("zq");
      do_cmd(0, 0, 255, 'hFFF0); settle(0, 0);
      do_cmd(0, 0, 255, 'h20);   settle(0, 0);
      check("sat_flag", err_sat, 1);
      check_book("sat");
      do_cmd(0, 1, 255, 'hFFFF); settle(0, 0);
      check("sat_level_qty", last_q, 'hFFFF);
      do_cmd(1, 1, 3, 1);   settle(0, 0);
      check("under_flag", err_under, 1);
      do_cmd(3, 0, 0, 0);   settle(0, 0);
      check("op_flag", err_op, 1);
      check_book("errs");
      pulse_err_clr();
      check("clr_sat", err_sat, 0);
      check("clr_under", err_under, 0);
      check("clr_op", err_op, 0);
      // err_clr wins over a same-cycle reserved op
      cmd_op = 2'b11; cmd_valid = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; err_clr = 1'b0;
      check("clr_prio_op", err_op, 0);
      check_book("clrp");

      // Clear one side: PRICE_LEVELS busy cycles
      apply_reset();
      do_cmd(0, 1, 0, 9);   settle(0, 0);
      do_cmd(0, 1, 128, 9); settle(0, 0);
      do_cmd(0, 1, 255, 9); settle(0, 0);
      do_cmd(0, 0, 0, 4);   settle(0, 0);
      check("pre_clr_ask_empty", ask_empty, 0);
      do_cmd(2, 1, 0, 0);
      n = 0;
      while (busy && n < 1000) begin
         check("clr_cmd_ready", cmd_ready, 0);
         check("clr_no_trade", trade_valid, 0);
         @(negedge clk);
         n++;
      end
      check("clr_cycles", n, 256);
      check("clr_ask_empty", ask_empty, 1);
      check_book("clr");

      // Reset while a trade is stalled
      apply_reset();
      trade_ready = 1'b0;
      do_cmd(0, 0, 50, 5);
      do_cmd(0, 1, 40, 5);
      n = 0;
      while (!trade_valid && n < 20) begin @(negedge clk); n++; end
      check("rst_mid_tv_before", trade_valid, 1);
      reset = 1'b1;
      #1;
      check("rst_mid_tv_async", trade_valid, 0);
      check("rst_mid_bid_empty", bid_empty, 1);
      check("rst_mid_ask_empty", ask_empty, 1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      trade_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check_book("rstm");

      // Randomized command stream against the model
      for (int it = 0; it < 200; it++) begin
         r    = int'($urandom_range(0, 99));
         side = int'($urandom_range(0, 1));
         px   = side ? int'($urandom_range(120, 160)) : int'($urandom_range(100, 140));
         qty  = int'($urandom_range(0, 40));
         if (r < 90) begin
            op = (r < 45) ? 0 : (r < 85) ? 1 : (r < 88) ? 3 : 2;
            do_cmd(op, side, px, qty);
            settle(0, 1);
         end else begin
            pulse_err_clr();
         end
         check_book("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
